// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared opcodes, sequencer states and decoded control bundle for the 4-bit computer
package cpu4_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'd0,
        OP_LDA,
        OP_ADD,
        OP_SUB,
        OP_OUT,
        OP_JMP,
        OP_JC,
        OP_HLT
    } opcode_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    typedef struct packed {
        logic acc_load;
        logic acc_add;
        logic acc_sub;
        logic out_load;
        logic jump;
        logic cond;
        logic halt;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode -> control bundle map
//   opcode  in   OPC_W  instruction opcode field
//   ctrl    out  ctrl_t strobes, jump/condition, halt and illegal flags
module instr_decode
    import cpu4_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_NOP: ;
            OP_LDA: ctrl.acc_load = 1'b1;
            OP_ADD: ctrl.acc_add = 1'b1;
            OP_SUB: ctrl.acc_sub = 1'b1;
            OP_OUT: ctrl.out_load = 1'b1;
            OP_JMP: ctrl.jump = 1'b1;
            OP_JC: begin
                ctrl.jump = 1'b1;
                ctrl.cond = 1'b1;
            end
            OP_HLT: ctrl.halt = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute sequencer driven by the PC phase strobe
//   clk, rst_n                 clock, async active-low reset
//   cp, program_count          PC phase strobe and current PC value
//   ab_flag                    ALU compare flag for JC
//   rom_addr, rom_data         program ROM read port
//   prog_c, prog_p, pc_ab_flag jump load request back into the PC
//   imm                        operand of the current instruction
//   acc_load..out_load         one-cycle datapath strobes
//   halted, illegal, overrun   status (illegal and overrun are sticky)
module instr_sequencer
    import cpu4_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cp,
    input  logic [ADDR_W-1:0]       program_count,
    input  logic                    ab_flag,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [OPC_W+DATA_W-1:0] rom_data,
    output logic                    prog_c,
    output logic [ADDR_W-1:0]       prog_p,
    output logic                    pc_ab_flag,
    output logic [DATA_W-1:0]       imm,
    output logic                    acc_load,
    output logic                    acc_add,
    output logic                    acc_sub,
    output logic                    out_load,
    output logic                    halted,
    output logic                    illegal,
    output logic                    overrun
);

    state_t            state, nxt;
    ctrl_t             dec;
    logic              cp_q, armed, pending, take_q, halt_q;
    logic [3:0]        strb_q;
    logic [1:0]        cnt;
    logic [OPC_W-1:0]  ir_op;
    logic [DATA_W-1:0] ir_opnd;
    logic              cp_rise, busy, fetch_done;

    // armed masks the first cycle after reset so a cp already high at release is not an edge
    assign cp_rise    = cp & ~cp_q & armed;
    assign busy       = state inside {S_FETCH, S_DECODE, S_EXEC};
    assign fetch_done = cnt == 2'(ROM_LAT - 1);
    assign halted     = state == S_HALT;

    instr_decode u_decode (
        .opcode (ir_op),
        .ctrl   (dec)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_WAIT;
        else        state <= nxt;

    always_comb begin
        nxt        = state;
        acc_load   = 1'b0;
        acc_add    = 1'b0;
        acc_sub    = 1'b0;
        out_load   = 1'b0;
        prog_c     = 1'b0;
        pc_ab_flag = 1'b0;
        case (state)
            S_WAIT:   if (cp_rise || pending) nxt = S_FETCH;
            S_FETCH:  if (fetch_done) nxt = S_DECODE;
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                nxt = halt_q ? S_HALT : S_WAIT;
                {acc_load, acc_add, acc_sub, out_load} = strb_q;
                prog_c     = take_q;
                pc_ab_flag = take_q;
            end
            default:  nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cp_q     <= 1'b0;
            armed    <= 1'b0;
            pending  <= 1'b0;
            cnt      <= '0;
            ir_op    <= '0;
            ir_opnd  <= '0;
            strb_q   <= '0;
            halt_q   <= 1'b0;
            take_q   <= 1'b0;
            rom_addr <= '0;
            prog_p   <= '0;
            imm      <= '0;
            illegal  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            cp_q  <= cp;
            armed <= 1'b1;
            case (state)
                S_WAIT: begin
                    cnt <= '0;
                    if (cp_rise || pending) begin
                        rom_addr <= program_count;
                        pending  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    cnt <= cnt + 2'd1;
                    if (fetch_done) {ir_op, ir_opnd} <= rom_data;
                end
                S_DECODE: begin
                    imm    <= ir_opnd;
                    strb_q <= {dec.acc_load, dec.acc_add, dec.acc_sub, dec.out_load};
                    halt_q <= dec.halt;
                    take_q <= dec.jump & (~dec.cond | ab_flag);
                    // the PC increments once after a load, so aim one below the target
                    if (dec.jump) prog_p <= ADDR_W'(ir_opnd) - ADDR_W'(1);
                    if (dec.illegal) illegal <= 1'b1;
                end
                default: ;
            endcase
            // only one early edge is remembered; it is served as soon as WAIT is reached
            if (busy && cp_rise) begin
                pending <= 1'b1;
                overrun <= 1'b1;
            end
        end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cp = 1'b0;
    logic       ab_flag = 1'b0;
    logic [3:0] program_count = '0;
    logic [3:0] rom_addr, prog_p, imm;
    logic [7:0] rom_data;
    logic       prog_c, pc_ab_flag, acc_load, acc_add, acc_sub, out_load;
    logic       halted, illegal, overrun;
    logic [7:0] rom [16];
    logic [5:0] strb;

    int errors = 0;
    int checks = 0;

    logic       m_halted = 1'b0;
    logic       m_illegal = 1'b0;
    logic       m_overrun = 1'b0;
    logic [3:0] m_last = '0;

    always #5 clk = ~clk;

    // single-cycle ROM: data is valid in the cycle the address is presented
    assign rom_data = rom[rom_addr];
    assign strb = {acc_load, acc_add, acc_sub, out_load, prog_c, pc_ab_flag};

    instr_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cp            (cp),
        .program_count (program_count),
        .ab_flag       (ab_flag),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .prog_c        (prog_c),
        .prog_p        (prog_p),
        .pc_ab_flag    (pc_ab_flag),
        .imm           (imm),
        .acc_load      (acc_load),
        .acc_add       (acc_add),
        .acc_sub       (acc_sub),
        .out_load      (out_load),
        .halted        (halted),
        .illegal       (illegal),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected {acc_load, acc_add, acc_sub, out_load, prog_c, pc_ab_flag} for one instruction
    function automatic logic [5:0] expect_strb(input logic [3:0] op, input logic ab);
        case (op)
            4'd1: return 6'b100000;
            4'd2: return 6'b010000;
            4'd3: return 6'b001000;
            4'd4: return 6'b000100;
            4'd5: return 6'b000011;
            4'd6: return ab ? 6'b000011 : 6'b000000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check(tag, {rom_addr, prog_p, imm, strb, halted, illegal, overrun}, 0);
    endtask

    task automatic do_reset();
        cp = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_outs");
        m_halted = 1'b0;
        m_illegal = 1'b0;
        m_overrun = 1'b0;
        m_last = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // one cp edge with no overlap; EXEC is expected three cycles after cp rises
    task automatic issue(input logic [3:0] pc, input logic ab, input int gap);
        logic [7:0] ins;
        logic [5:0] want;
        logic [3:0] tgt;
        ins = rom[pc];
        want = m_halted ? 6'd0 : expect_strb(ins[7:4], ab);
        tgt = ins[3:0] - 4'd1;
        program_count = pc;
        ab_flag = ab;
        cp = 1'b1;
        step();
        cp = 1'b0;
        check("fetch_addr", rom_addr, m_halted ? m_last : pc);
        check("strb_fetch", strb, 0);
        step();
        check("strb_decode", strb, 0);
        step();
        check("strb_exec", strb, want);
        if (!m_halted) begin
            check("imm", imm, ins[3:0]);
            if (want[1]) check("prog_p", prog_p, tgt);
            m_last = pc;
            m_halted = ins[7:4] == 4'd7;
            m_illegal = m_illegal | (ins[7:4] >= 4'd8);
        end
        step();
        check("strb_post", strb, 0);
        check("halted", halted, m_halted);
        check("illegal", illegal, m_illegal);
        check("overrun", overrun, m_overrun);
        for (int i = 0; i < gap; i++) begin
            step();
            check("strb_idle", strb, 0);
        end
    endtask

    initial begin
        logic [3:0] rpc, op;
        logic       rab;
        logic [7:0] ins;

        for (int a = 0; a < 16; a++) rom[a] = 8'h00;

        // cp already high when reset releases must not start a fetch
        cp = 1'b1;
        program_count = 4'd9;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_outs");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_edge_addr", rom_addr, 0);
            check("no_edge_strb", strb, 0);
        end
        cp = 1'b0;
        step();

        // LDA 7
        rom[3] = 8'h17;
        issue(4'd3, 1'b0, 2);
        // JMP 10, then the PC lands on 10
        rom[5] = 8'h5A;
        rom[10] = 8'h4B;
        issue(4'd5, 1'b0, 2);
        issue(4'd10, 1'b0, 2);
        // JC 0 not taken, then taken with wrap to 15
        rom[2] = 8'h60;
        issue(4'd2, 1'b0, 2);
        issue(4'd2, 1'b1, 2);
        // undefined opcode
        rom[7] = 8'hC5;
        issue(4'd7, 1'b0, 2);

        // randomized program with a PC that follows taken jumps
        for (int a = 0; a < 16; a++) begin
            op = 4'($urandom_range(0, 14));
            if (op >= 4'd7) op = op + 4'd1;
            rom[a] = {op, 4'($urandom)};
        end
        rpc = 4'($urandom);
        for (int i = 0; i < 40; i++) begin
            rab = 1'($urandom);
            issue(rpc, rab, $urandom_range(0, 6));
            ins = rom[rpc];
            if (ins[7:4] == 4'd5 || (ins[7:4] == 4'd6 && rab)) rpc = ins[3:0];
            else rpc = 4'($urandom);
        end

        // halt: later edges do nothing until reset
        do_reset();
        rom[3] = 8'h17;
        rom[4] = 8'h70;
        issue(4'd4, 1'b0, 1);
        issue(4'd3, 1'b0, 1);
        issue(4'd3, 1'b1, 1);
        do_reset();
        check("halt_cleared", halted, 0);
        issue(4'd3, 1'b0, 1);

        // overrun: second edge while decoding
        do_reset();
        rom[1] = 8'h23;
        rom[6] = 8'h34;
        program_count = 4'd1;
        cp = 1'b1;
        step();
        cp = 1'b0;
        check("ovr_a_addr1", rom_addr, 1);
        step();
        program_count = 4'd6;
        cp = 1'b1;
        step();
        check("ovr_a_exec1", strb, 6'b010000);
        check("ovr_a_flag", overrun, 1);
        cp = 1'b0;
        step();
        check("ovr_a_wait", strb, 0);
        step();
        check("ovr_a_addr2", rom_addr, 6);
        step();
        check("ovr_a_dec2", strb, 0);
        step();
        check("ovr_a_exec2", strb, 6'b001000);
        step();
        check("ovr_a_post", strb, 0);

        // overrun: edge on the EXEC -> WAIT cycle
        do_reset();
        program_count = 4'd1;
        cp = 1'b1;
        step();
        cp = 1'b0;
        step();
        step();
        check("ovr_b_exec1", strb, 6'b010000);
        check("ovr_b_clear", overrun, 0);
        program_count = 4'd6;
        cp = 1'b1;
        step();
        cp = 1'b0;
        check("ovr_b_flag", overrun, 1);
        check("ovr_b_wait", strb, 0);
        step();
        check("ovr_b_addr2", rom_addr, 6);
        step();
        step();
        check("ovr_b_exec2", strb, 6'b001000);
        step();
        check("ovr_b_post", strb, 0);

        // reset during DECODE of an ADD
        do_reset();
        program_count = 4'd1;
        cp = 1'b1;
        step();
        cp = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst_outs");
        step();
        check("mid_rst_strb", strb, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mid_rst_after", strb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Consumer and jump initiator on the program-counter interface of the 4-bit computer.
- On each rising edge of the PC phase strobe `cp`, it:
  - samples the program count,
  - fetches an 8-bit instruction from program ROM,
  - decodes it and emits one-cycle datapath strobes.
- For taken jumps it drives `prog_c`/`prog_p`/`pc_ab_flag` back into the PC.

Parameters:
- ADDR_W, 4, program counter / ROM address width
- DATA_W, 4, operand and accumulator data width; instruction width = 4 + DATA_W
- ROM_LAT, 1, ROM read latency in clk cycles; legal values 1 or 2

Ports:
- clk  in  1  system clock, the same clock that drives the PC
- rst_n  in  1  asynchronous active-low reset
- cp  in  1  PC phase strobe; a rising edge means program_count is valid
- program_count  in  ADDR_W  current PC value
- ab_flag  in  1  ALU compare flag, used by JC
- rom_addr  out  ADDR_W  program ROM read address
- rom_data  in  4+DATA_W  ROM read data; [7:4] opcode, [3:0] operand
- prog_c  out  1  jump load request to the PC
- prog_p  out  ADDR_W  jump load value to the PC
- pc_ab_flag  out  1  jump qualifier to the PC; the PC loads only when prog_c and pc_ab_flag are both 1
- imm  out  DATA_W  operand of the current instruction
- acc_load, acc_add, acc_sub, out_load  out  1 each  one-cycle datapath strobes
- halted  out  1  high from HLT until reset
- illegal  out  1  sticky; set by an undefined opcode
- overrun  out  1  sticky; set when a cp edge arrives outside WAIT

Behaviour:
- Reset (async, rst_n=0):
  - state=WAIT; cp_q=0; pending=0.
  - All outputs 0, including rom_addr, prog_p and imm.
- Edge detect:
  - cp_q <= cp.
  - edge = cp & ~cp_q.
  - If cp is already high when reset releases, that is not an edge.
- States: WAIT, FETCH, DECODE, EXEC, HALT.
- WAIT:
  - On edge (or on pending=1): rom_addr <= program_count, clear pending, go to FETCH.
- FETCH:
  - Hold for ROM_LAT cycles, then capture rom_data into the instruction register and go to DECODE.
- DECODE:
  - imm <= operand.
  - Compute the strobe set and the jump decision; go to EXEC.
- EXEC:
  - Exactly one cycle.
  - Assert the decoded strobes and, if the jump is taken, prog_c=1, pc_ab_flag=1 and prog_p.
  - Go to WAIT, or to HALT on HLT.
- Latency: edge at cycle 0 puts EXEC at cycle 2+ROM_LAT. Total latency must stay below the 16-clk PC period.
- Opcodes:
  - 0 NOP: no strobes.
  - 1 LDA: acc_load.
  - 2 ADD: acc_add.
  - 3 SUB: acc_sub.
  - 4 OUT: out_load.
  - 5 JMP: jump always taken.
  - 6 JC: jump taken iff ab_flag=1, sampled in DECODE.
  - 7 HLT.
  - 8–15: behave as NOP and set illegal.
- Jump target:
  - The PC increments once after a load, before its next cp edge.
  - Therefore prog_p = operand - 1 mod 2^ADDR_W, so the next executed address equals the operand.
  - Operand 0 gives prog_p=15.
- prog_c is a single-cycle pulse. pc_ab_flag=0 whenever prog_c=0.
- HALT: no strobes, no fetches, cp edges ignored, halted=1. Exit only via rst_n.
- Overrun:
  - A cp edge in FETCH, DECODE or EXEC sets pending=1 and overrun=1.
  - Only one edge is remembered; further edges are dropped.
- Simultaneous: an edge in the same cycle as EXEC→WAIT counts as overrun and is served from pending in the next cycle.
- Reset mid-operation: any in-flight instruction is discarded; no strobe or prog_c is emitted after rst_n falls.

Decomposition:
- Shared package cpu4_pkg holds:
  - opcode enum (NOP, LDA, ADD, SUB, OUT, JMP, JC, HLT),
  - state enum,
  - OPC_W=4,
  - the ctrl_t struct {acc_load, acc_add, acc_sub, out_load, jump, cond, halt, illegal}.
- One combinational sub-module, instr_decode, maps opcode → ctrl_t. The sequencer owns the FSM, edge detection, pending/sticky logic and target arithmetic.

Test Plan:
- Reset, then cp rises with program_count=3 and ROM[3]=0x17 → 3 cycles later (ROM_LAT=1): acc_load for 1 cycle, imm=7, prog_c=0.
- ROM[5]=0x5A (JMP 10), cp edge with pc=5 → prog_c=1 and pc_ab_flag=1 for 1 cycle, prog_p=9. With the PC model attached, the next fetch rom_addr=10.
- ROM[2]=0x60, ab_flag=0 → no prog_c. Repeat with ab_flag=1 → prog_p=15.
- ROM[4]=0x70 → halted=1. Subsequent cp edges produce no rom_addr change and no strobes until rst_n pulses low, after which halted=0.
- Second cp edge injected during FETCH → overrun=1, and the second instruction executes immediately after the first EXEC. Opcode 0xC → illegal=1 with no strobes.
- rst_n asserted in DECODE of an ADD → acc_add never pulses; all outputs 0 asynchronously.
